// File: rtl/vadd_result_stage.sv
// vadd_result_stage: two-stage result pipeline behind the vector add unit.
// Strips the per-byte guard columns from the guarded sum, extracts one
// carry/borrow flag per element according to SEW, and hands either the data
// or the packed flag mask to writeback under a valid/ready handshake.
module vadd_result_stage #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int OPSEL_WIDTH    = 6,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REQ_DATA_WIDTH+16:0] in_sum,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic [OPSEL_WIDTH-1:0]     in_opSel,
  input  logic                       in_mask_mode,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REQ_DATA_WIDTH-1:0]  out_data,
  output logic [7:0]                 out_flags,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  localparam int LANES = 8;
  localparam int CHUNK = 10;

  // Stage 1 holding registers; the topmost sum bit is never needed.
  logic                       s1V_q, s1V_d;
  logic [LANES*CHUNK-1:0]     s1Sum_q;
  logic [SEW_WIDTH-1:0]       s1Sew_q;
  logic                       s1Signed_q;
  logic                       s1Mask_q;
  logic [TAG_WIDTH-1:0]       s1Tag_q;

  // Stage 2 registers drive the outputs directly.
  logic                       s2V_q, s2V_d;
  logic [REQ_DATA_WIDTH-1:0]  s2Data_q;
  logic [7:0]                 s2Flags_q;
  logic [TAG_WIDTH-1:0]       s2Tag_q;

  logic                       s2Adv, s1Adv, accept;
  logic [LANES-1:0]           colBits;
  logic                       inv;
  logic [REQ_DATA_WIDTH-1:0]  dataBytes;
  logic [7:0]                 decFlags;
  logic [REQ_DATA_WIDTH-1:0]  decData;

  // Only opSel[4] and the low 80 sum bits carry information.
  logic unused_inputs;
  assign unused_inputs = ^{in_sum[REQ_DATA_WIDTH+16], in_opSel[OPSEL_WIDTH-1:5], in_opSel[3:0]};

  // Handshake: S2 frees up when empty or drained; S1 accepts when it empties this cycle.
  always_comb begin
    s2Adv    = ~s2V_q | out_ready;
    s1Adv    = s1V_q & s2Adv;
    in_ready = ~s1V_q | s2Adv;
    accept   = in_valid & in_ready;
    s1V_d    = s1V_q;
    if (accept) begin
      s1V_d = 1'b1;
    end else if (s1Adv) begin
      s1V_d = 1'b0;
    end
    s2V_d = s2V_q;
    if (s2Adv) begin
      s2V_d = s1V_q;
    end
  end

  // Stage 1 capture of the raw guarded sum and sideband.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1V_q      <= 1'b0;
      s1Sum_q    <= '0;
      s1Sew_q    <= '0;
      s1Signed_q <= 1'b0;
      s1Mask_q   <= 1'b0;
      s1Tag_q    <= '0;
    end else begin
      s1V_q <= s1V_d;
      if (accept) begin
        s1Sum_q    <= in_sum[LANES*CHUNK-1:0];
        s1Sew_q    <= in_sew;
        s1Signed_q <= in_opSel[4];
        s1Mask_q   <= in_mask_mode;
        s1Tag_q    <= in_tag;
      end
    end
  end

  // Guard stripping and per-element flag pick: the flag of an element is the
  // raw column above its most significant byte, inverted in unsigned mode.
  always_comb begin
    colBits   = '0;
    dataBytes = '0;
    for (int i = 0; i < LANES; i++) begin
      colBits[i]          = s1Sum_q[CHUNK*i+9];
      dataBytes[8*i +: 8] = s1Sum_q[CHUNK*i+1 +: 8];
    end
    inv      = ~s1Signed_q;
    decFlags = '0;
    case (s1Sew_q)
      2'd0: decFlags = colBits ^ {LANES{inv}};
      2'd1: begin
        for (int e = 0; e < 4; e++) begin
          decFlags[e] = colBits[2*e+1] ^ inv;
        end
      end
      2'd2: begin
        for (int e = 0; e < 2; e++) begin
          decFlags[e] = colBits[4*e+3] ^ inv;
        end
      end
      default: decFlags[0] = colBits[7] ^ inv;
    endcase
    decData = s1Mask_q ? {{(REQ_DATA_WIDTH-8){1'b0}}, decFlags} : dataBytes;
  end

  // Stage 2 output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2V_q     <= 1'b0;
      s2Data_q  <= '0;
      s2Flags_q <= '0;
      s2Tag_q   <= '0;
    end else begin
      s2V_q <= s2V_d;
      if (s1Adv) begin
        s2Data_q  <= decData;
        s2Flags_q <= decFlags;
        s2Tag_q   <= s1Tag_q;
      end
    end
  end

  assign out_valid = s2V_q;
  assign out_data  = s2Data_q;
  assign out_flags = s2Flags_q;
  assign out_tag   = s2Tag_q;

endmodule

// File: tb/tb_vadd_result_stage.sv
// Scoreboard bench for vadd_result_stage: directed decode cases, a stalled
// stream, reset flush and a random handshake run.
module tb_vadd_result_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [80:0] in_sum = '0;
  logic [1:0]  in_sew = '0;
  logic [5:0]  in_opSel = '0;
  logic        in_mask_mode = 1'b0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [7:0]  out_flags;
  logic [4:0]  out_tag;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  f;
    logic [4:0]  t;
  } expT;

  expT  sbQueue[$];
  expT  pendExp;
  logic accNow, conNow;
  int   checks = 0;
  int   passed = 0;
  int   outCount = 0;

  vadd_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_sew(in_sew), .in_opSel(in_opSel),
    .in_mask_mode(in_mask_mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .out_tag(out_tag)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [80:0] makeSum(input logic [7:0] c, input logic [63:0] d,
                                          input logic [7:0] g, input logic b80);
    logic [80:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[10*i]         = g[i];
      s[10*i+1 +: 8]  = d[8*i +: 8];
      s[10*i+9]       = c[i];
    end
    s[80] = b80;
    return s;
  endfunction

  function automatic expT model(input logic [80:0] s, input logic [1:0] sew, input logic op4,
                                input logic mask, input logic [4:0] tag);
    expT r;
    int  b, n;
    b = 1 << sew;
    n = 8 / b;
    r.d = '0;
    r.f = '0;
    for (int i = 0; i < 8; i++) r.d[8*i +: 8] = s[10*i+1 +: 8];
    for (int e = 0; e < 8; e++) begin
      if (e < n) r.f[e] = s[10*(e*b+b-1)+9] ^ ~op4;
    end
    if (mask) r.d = {56'b0, r.f};
    r.t = tag;
    return r;
  endfunction

  // Drive one cycle's inputs at the falling edge and check against the scoreboard.
  task automatic applyStimulus(input logic v, input logic [80:0] s, input logic [1:0] sew,
                               input logic op4, input logic mask, input logic [4:0] tag,
                               input logic ordy);
    logic [5:0] op;
    @(negedge clk);
    op = 6'($urandom);
    op[4] = op4;
    in_valid = v; in_sum = s; in_sew = sew; in_opSel = op;
    in_mask_mode = mask; in_tag = tag; out_ready = ordy;
    #1;
    checkOutput("in_ready", in_ready, !(sbQueue.size() >= 2 && !ordy));
    if (sbQueue.size() == 0) checkOutput("idle_valid", out_valid, 0);
    else if (sbQueue.size() >= 2) checkOutput("full_valid", out_valid, 1);
    if (out_valid && sbQueue.size() > 0) begin
      checkOutput("sb_data", out_data, sbQueue[0].d);
      checkOutput("sb_flags", out_flags, sbQueue[0].f);
      checkOutput("sb_tag", out_tag, sbQueue[0].t);
    end
    accNow = v && in_ready;
    conNow = out_valid && out_ready;
    if (accNow) pendExp = model(s, sew, op4, mask, tag);
  endtask

  // Commit the handshakes seen this cycle at the rising edge.
  task automatic endCycle();
    @(posedge clk);
    if (conNow) begin
      outCount++;
      if (sbQueue.size() > 0) void'(sbQueue.pop_front());
    end
    if (accNow) sbQueue.push_back(pendExp);
  endtask

  task automatic idleCycle(input logic ordy);
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b0, 5'd0, ordy);
    endCycle();
  endtask

  task automatic runDirected(input string name, input logic [80:0] s, input logic [1:0] sew,
                             input logic op4, input logic mask, input logic [4:0] tag,
                             input logic [63:0] expD, input logic [7:0] expF);
    applyStimulus(1'b1, s, sew, op4, mask, tag, 1'b1);
    endCycle();
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput({name, "_lat1"}, out_valid, 0);
    endCycle();
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput({name, "_lat2"}, out_valid, 1);
    checkOutput({name, "_data"}, out_data, expD);
    checkOutput({name, "_flags"}, out_flags, {56'b0, expF});
    checkOutput({name, "_tag"}, out_tag, {59'b0, tag});
    endCycle();
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbQueue.delete();
    accNow = 1'b0;
    conNow = 1'b0;
  endtask

  initial begin
    logic [7:0]  c;
    logic [63:0] d;
    int          idx, startCount;
    logic        sawStall;
    accNow = 1'b0;
    conNow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_flags", out_flags, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    endCycle();

    // Directed decode cases
    runDirected("sew0_plain", makeSum(8'hFF, 64'h0101010101010101, 8'h00, 1'b0),
                2'd0, 1'b0, 1'b0, 5'd3, 64'h0101010101010101, 8'h00);
    d = {$urandom, $urandom};
    runDirected("sew0_mask", makeSum(8'hAA, d, 8'($urandom), 1'b1),
                2'd0, 1'b0, 1'b1, 5'd7, 64'h55, 8'h55);
    c = 8'($urandom); c[3] = 1'b1; c[7] = 1'b0;
    d = {$urandom, $urandom};
    runDirected("sew2_signed", makeSum(c, d, 8'($urandom), 1'b0),
                2'd2, 1'b1, 1'b0, 5'd9, d, 8'h01);
    c = 8'($urandom); c[7] = 1'b0;
    d = {$urandom, $urandom};
    runDirected("sew3_unsigned", makeSum(c, d, 8'($urandom), 1'b1),
                2'd3, 1'b0, 1'b0, 5'd12, d, 8'h01);
    c = 8'($urandom) | 8'hAA;
    d = {$urandom, $urandom};
    runDirected("sew1_unsigned", makeSum(c, d, 8'($urandom), 1'b0),
                2'd1, 1'b0, 1'b0, 5'd21, d, 8'h00);

    // Back-to-back stream with a three-cycle stall
    idx = 0;
    sawStall = 1'b0;
    startCount = outCount;
    for (int cyc = 0; cyc < 40 && (idx < 6 || sbQueue.size() > 0); cyc++) begin
      applyStimulus(idx < 6, makeSum(8'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b0),
                    2'($urandom), 1'($urandom), 1'($urandom), 5'(idx),
                    !(cyc >= 2 && cyc <= 4));
      if (!in_ready) sawStall = 1'b1;
      if (accNow) idx++;
      endCycle();
    end
    checkOutput("stream_stall_seen", sawStall, 1);
    checkOutput("stream_sent", idx, 6);
    checkOutput("stream_received", outCount - startCount, 6);
    checkOutput("stream_drained", sbQueue.size(), 0);

    // Reset with two entries in flight
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, makeSum(8'($urandom), {$urandom, $urandom}, 8'($urandom), 1'b0),
                    2'd0, 1'b0, 1'b0, 5'(20 + k), 1'b0);
      endCycle();
    end
    doReset();
    applyStimulus(1'b0, '0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_in_ready", in_ready, 1);
    endCycle();
    repeat (4) idleCycle(1'b1);

    // Random traffic, then drain
    for (int cyc = 0; cyc < 60; cyc++) begin
      applyStimulus(1'($urandom), makeSum(8'($urandom), {$urandom, $urandom}, 8'($urandom), 1'($urandom)),
                    2'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      endCycle();
    end
    for (int cyc = 0; cyc < 10 && sbQueue.size() > 0; cyc++) idleCycle(1'b1);
    checkOutput("random_drained", sbQueue.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vadd_result_stage.md
# vadd_result_stage

Two-stage pipelined result stage that sits directly downstream of the vector add unit. Each cycle it can accept one 81-bit guarded sum, in which every byte lane carries a guard bit below it and a sign/carry column above it. It strips the guard columns to recover the packed 64-bit result, extracts one carry/borrow flag per element according to SEW, and presents either the data or the packed flag mask to writeback under a valid/ready handshake.

## Interface
- REQ_DATA_WIDTH, 64, data width; only 64 is supported
- SEW_WIDTH, 2, element-width code width
- OPSEL_WIDTH, 6, operation-select width
- TAG_WIDTH, 5, destination tag width, passed through unchanged
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_sum and the sideband inputs are valid
- in_ready  out  1  stage can accept this cycle
- in_sum  in  REQ_DATA_WIDTH+17  guarded sum from the add unit
- in_sew  in  SEW_WIDTH  0=8b, 1=16b, 2=32b, 3=64b elements
- in_opSel  in  OPSEL_WIDTH  opcode select; only bit 4 (signed-column mode) is used
- in_mask_mode  in  1  1 = emit flag mask instead of data
- in_tag  in  TAG_WIDTH  destination tag
- out_valid  out  1  output holds a result
- out_ready  in  1  consumer accepts this cycle
- out_data  out  REQ_DATA_WIDTH  result data or packed mask
- out_flags  out  8  per-element flags, element index order
- out_tag  out  TAG_WIDTH  tag of the presented result

## Operation
- in_sum layout: chunk i (i=0..7) = in_sum[10i+9:10i].
  - bit 10i: guard column, discarded.
  - bits 10i+8:10i+1: data byte i.
  - bit 10i+9: raw column c_i.
  - in_sum[80]: ignored.
- Data extraction is independent of SEW: data[8i+7:8i] = in_sum[10i+8:10i+1].
- Flag inversion: inv = ~opSel[4]. In unsigned mode the column is 1+0, so a set raw bit means no carry.
- Element size is B bytes, with B = 1, 2, 4, 8 for in_sew = 0..3. Number of elements N = 8/B.
- Flag for element e (e < N): flag_e = c_(eB+B-1) ^ inv.
- out_flags[e] = flag_e for e < N; out_flags[7:N] = 0.
- out_data = data when the captured in_mask_mode = 0; otherwise {56'b0, out_flags}.
- Stage 1 (S1) registers in_sum, in_sew, opSel[4], in_mask_mode and in_tag. It has its own valid bit, s1_v.
- Stage 2 (S2) registers the decoded out_data, out_flags and out_tag. Its valid bit s2_v drives out_valid.
- Flow control:
  - s2_adv = ~s2_v | out_ready
  - s1_adv = s1_v & s2_adv
  - in_ready = ~s1_v | s2_adv
- in_ready depends combinationally on out_ready; no other combinational path exists from input to output.
- Accept happens when in_valid & in_ready. On accept, S1 loads and s1_v is set to 1.
- When s2_adv is high, S2 loads from S1 (s2_v <= s1_v). When an S1 entry moves to S2 and there is no new accept in the same cycle, s1_v clears.
- When S2 is held (out_valid & ~out_ready), out_data, out_flags and out_tag must stay stable.
- Simultaneous accept and S1 advance in one cycle: S1 takes the new entry and S2 takes the old one; nothing is lost or duplicated.
- When in_valid is low, S1 register contents are don't-care, but s1_v must clear once its entry advances.

## Timing
- Reset: s1_v = 0, s2_v = 0, out_valid = 0, out_data = 0, out_flags = 0, out_tag = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation drops all in-flight entries; no output appears afterwards for inputs accepted before reset.
- Latency: an input accepted at edge k appears with out_valid = 1 after edge k+1 when out_ready is held high.
- Throughput: 1 result per cycle with out_ready held high.
- Full condition: s1_v & s2_v & ~out_ready gives in_ready = 0.
- Backpressure: after out_ready drops, at most 2 entries are buffered.
- Order: results are strictly in-order and tags are preserved.

## Test plan
- After reset, out_valid=0, outputs zero, in_ready=1. SEW=0, unsigned, every chunk 10'b1_00000001_0, tag 3 -> two cycles later out_data=0x0101010101010101, out_flags=0x00, out_tag=3.
- SEW=0, unsigned, mask_mode=1, chunk i raw c_i=(i odd) -> out_flags=0x55, out_data=0x55.
- SEW=2, opSel[4]=1, c_3=1, c_7=0, other c bits random -> out_flags=0x01; bits 7:2 are 0.
- SEW=3, unsigned, c_7=0 -> out_flags=0x01. SEW=1, c_1=c_3=c_5=c_7=1, unsigned -> out_flags=0x00.
- Stream 6 back-to-back inputs with tags 0..5, out_ready low for cycles 2-4. Required: in_ready drops when both stages are full, outputs stay stable while held, tags emerge 0..5 in order with no loss or duplication.
- Accept 2 entries, then assert rst for 1 cycle with out_ready low -> out_valid=0 and in_ready=1 afterwards, and no stale tag appears later.
